cache_line_refill_ctrl: RTL and testbench

BIU-side responder to the cache tag arbiter. It consumes the arbiter's miss, dirty-replace and force-sync requests and runs the memory bursts they need. A dirty victim line is written back to memory from cache memory, then the missing line is fetched into the selected entry. Completion is reported to the arbiter with writeback_ok and line_refill pulses.

---
 rtl/cache_line_refill_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cache_line_refill_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_refill_ctrl.sv
// BIU-side line refill controller: writes back a dirty victim line, then fetches the missing
// line into the selected cache-memory entry, pulsing writeback_ok / line_refill on completion.
module cache_line_refill_ctrl #(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned WIDX       = $clog2(LINE_WORDS),
    parameter int unsigned SEL_WIDTH  = 3,
    parameter int unsigned LINE_LSB   = $clog2(LINE_WORDS * 4)
) (
    input  logic                 clk,
    input  logic                 rst,
    // Arbiter side
    input  logic                 line_miss,
    input  logic                 replace_dirty,
    input  logic                 force_sync,
    input  logic [SEL_WIDTH-1:0] entry_replace_sel,
    input  logic [31:0]          miss_addr,
    input  logic [31:0]          victim_addr,
    output logic [31:0]          refill_pa,
    output logic                 line_refill,
    output logic                 writeback_ok,
    output logic                 busy,
    // Cache memory side
    output logic [SEL_WIDTH-1:0] cm_entry,
    output logic [WIDX-1:0]      cm_word,
    input  logic [31:0]          cm_rdata,
    output logic                 cm_we,
    output logic [31:0]          cm_wdata,
    // Bus side
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [31:0]          bus_addr,
    output logic [31:0]          bus_wdata,
    input  logic [31:0]          bus_rdata,
    input  logic                 bus_ack
);

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StWbDone,
        StRf,
        StRfDone
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDX-1:0]        word_q, word_d;
    logic [SEL_WIDTH-1:0]   ent_q, ent_d;
    logic [31:0]            base_q, base_d;

    logic                   last_word;
    logic [31:0]            word_offset;
    logic [31:0]            victim_base;
    logic [31:0]            miss_base;
    logic [2*LINE_LSB-1:0]  unused_low_bits;

    assign last_word   = (word_q == WIDX'(LINE_WORDS - 1));
    assign word_offset = 32'(word_q) << 2;
    assign victim_base = {victim_addr[31:LINE_LSB], {LINE_LSB{1'b0}}};
    assign miss_base   = {miss_addr[31:LINE_LSB], {LINE_LSB{1'b0}}};

    // Byte offsets inside a line never reach the bus; the line base is all that matters.
    assign unused_low_bits = {victim_addr[LINE_LSB-1:0], miss_addr[LINE_LSB-1:0]};

    // Next-state logic
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        ent_d   = ent_q;
        base_d  = base_q;

        unique case (state_q)
            StIdle: begin
                // A dirty victim must reach memory before its entry is overwritten.
                if (replace_dirty && (line_miss || force_sync)) begin
                    ent_d   = entry_replace_sel;
                    base_d  = victim_base;
                    word_d  = '0;
                    state_d = StWb;
                end else if (line_miss) begin
                    ent_d   = entry_replace_sel;
                    base_d  = miss_base;
                    word_d  = '0;
                    state_d = StRf;
                end
            end

            StWb: begin
                if (bus_ack) begin
                    if (last_word) begin
                        word_d  = '0;
                        state_d = StWbDone;
                    end else begin
                        word_d = word_q + WIDX'(1);
                    end
                end
            end

            StWbDone: begin
                state_d = StIdle;
            end

            StRf: begin
                if (bus_ack) begin
                    if (last_word) begin
                        word_d  = '0;
                        state_d = StRfDone;
                    end else begin
                        word_d = word_q + WIDX'(1);
                    end
                end
            end

            StRfDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                word_d  = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            word_q  <= '0;
            ent_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            ent_q   <= ent_d;
            base_q  <= base_d;
        end
    end

    // Output decode: bus and handshake outputs follow the state only; the cache-memory
    // port also tracks bus_ack so refill data is written in the beat it arrives.
    always_comb begin
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_addr     = '0;
        bus_wdata    = '0;
        busy         = 1'b1;
        writeback_ok = 1'b0;
        line_refill  = 1'b0;
        refill_pa    = '0;
        cm_entry     = ent_q;
        cm_word      = word_q;
        cm_we        = 1'b0;
        cm_wdata     = bus_rdata;

        unique case (state_q)
            StIdle: begin
                busy     = 1'b0;
                cm_entry = entry_replace_sel;
            end

            StWb: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = base_q + word_offset;
                bus_wdata = cm_rdata;
            end

            StWbDone: begin
                writeback_ok = 1'b1;
            end

            StRf: begin
                bus_req  = 1'b1;
                bus_addr = base_q + word_offset;
                cm_we    = bus_ack;
            end

            StRfDone: begin
                line_refill = 1'b1;
                refill_pa   = base_q;
            end

            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_line_refill_ctrl.sv
// Self-checking bench for cache_line_refill_ctrl: bus/cache-memory responder plus a line-level
// reference model that predicts every beat, cache-memory word and completion pulse.
module tb_cache_line_refill_ctrl;

    localparam int unsigned LW   = 8;
    localparam int unsigned SW   = 3;
    localparam int unsigned WI   = $clog2(LW);
    localparam logic [31:0] MASK = ~32'(LW * 4 - 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          line_miss, replace_dirty, force_sync;
    logic [SW-1:0] entry_replace_sel;
    logic [31:0]   miss_addr, victim_addr, refill_pa;
    logic          line_refill, writeback_ok, busy;
    logic [SW-1:0] cm_entry;
    logic [WI-1:0] cm_word;
    logic [31:0]   cm_rdata, cm_wdata;
    logic          cm_we;
    logic          bus_req, bus_we, bus_ack;
    logic [31:0]   bus_addr, bus_wdata, bus_rdata;

    always #5 clk = ~clk;

    cache_line_refill_ctrl #(.LINE_WORDS(LW), .SEL_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .line_miss(line_miss), .replace_dirty(replace_dirty), .force_sync(force_sync),
        .entry_replace_sel(entry_replace_sel), .miss_addr(miss_addr),
        .victim_addr(victim_addr), .refill_pa(refill_pa), .line_refill(line_refill),
        .writeback_ok(writeback_ok), .busy(busy),
        .cm_entry(cm_entry), .cm_word(cm_word), .cm_rdata(cm_rdata), .cm_we(cm_we),
        .cm_wdata(cm_wdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    // Cache memory model: combinational read, clocked write
    logic [31:0] cmem [2**SW][LW];
    assign cm_rdata = cmem[cm_entry][cm_word];
    always @(posedge clk) if (cm_we) cmem[cm_entry][cm_word] <= cm_wdata;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Backing-memory contents as a pure function of the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       beats[$];
    int          ack_mode = 0;   // 0 every cycle, 1 every 3rd, 2 random, 3 forced high
    int          phase_cnt = 0;
    int          n_wb = 0;
    int          n_rf = 0;
    logic [31:0] last_pa = '0;
    logic        prev_pend = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr, prev_wdata;

    // Bus responder and transfer monitor
    always @(negedge clk) begin
        case (ack_mode)
            0:       bus_ack = 1'b1;
            1:       bus_ack = (phase_cnt % 3 == 2);
            3:       bus_ack = 1'b1;
            default: bus_ack = 1'($urandom_range(0, 1));
        endcase
        if (bus_req) phase_cnt++;
        bus_rdata = mem_word(bus_addr);
        #1;
        if (prev_pend && bus_req) begin
            check("hold_addr", bus_addr, prev_addr);
            check("hold_wdata", bus_wdata, prev_wdata);
            check("hold_we", 32'(bus_we), 32'(prev_we));
        end
        if (bus_req && !bus_we) check("cm_we_beat", 32'(cm_we), 32'(bus_ack));
        if (!bus_req) check("cm_we_idle", 32'(cm_we), 32'd0);
        if (bus_req && bus_ack)
            beats.push_back('{we: bus_we, addr: bus_addr, data: bus_we ? bus_wdata : bus_rdata});
        prev_pend  = bus_req && !bus_ack;
        prev_addr  = bus_addr;
        prev_wdata = bus_wdata;
        prev_we    = bus_we;
        #1;
        if (writeback_ok) n_wb++;
        if (line_refill) begin
            n_rf++;
            last_pa = refill_pa;
        end
    end

    logic [31:0] snap  [LW];
    logic [31:0] snap2 [LW];

    // Wait for the next writeback_ok (wb=1) or line_refill (wb=0); k counts clock edges.
    task automatic wait_pulse(input bit wb, output int k, output bit seen);
        int c0;
        c0   = wb ? n_wb : n_rf;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 400) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            #3;
            if ((wb ? n_wb : n_rf) != c0) seen = 1'b1;
        end
    endtask

    // One arbiter request: optional write-back of the victim, then the refill.
    task automatic run_txn(input bit dirty, input logic [SW-1:0] sel, input logic [31:0] va,
                           input logic [31:0] ma, input int mode, input bit chk_lat);
        logic [31:0] vbase, mbase, ea, ed;
        logic        ewe;
        int          wb0, rf0, k, nexp, idx;
        bit          seen;
        vbase = va & MASK;
        mbase = ma & MASK;
        for (int i = 0; i < LW; i++) snap[i] = cmem[sel][i];
        beats.delete();
        wb0 = n_wb;
        rf0 = n_rf;
        ack_mode  = mode;
        phase_cnt = 0;
        @(posedge clk);
        #1;
        line_miss         = 1'b1;
        replace_dirty     = dirty;
        entry_replace_sel = sel;
        victim_addr       = va;
        miss_addr         = ma;
        if (dirty) begin
            wait_pulse(1'b1, k, seen);
            check("wb_seen", 32'(seen), 32'd1);
            @(posedge clk);
            #1;
            replace_dirty = 1'b0;
        end
        wait_pulse(1'b0, k, seen);
        check("rf_seen", 32'(seen), 32'd1);
        if (chk_lat) check("rf_latency", 32'(k), 32'd9);
        check("refill_pa", last_pa, mbase);
        @(posedge clk);
        #1;
        line_miss         = 1'b0;
        entry_replace_sel = SW'($urandom);
        miss_addr         = $urandom;
        repeat (2) @(posedge clk);
        #3;
        check("wb_count", 32'(n_wb - wb0), 32'(dirty));
        check("rf_count", 32'(n_rf - rf0), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        nexp = dirty ? 2 * LW : LW;
        check("beat_count", 32'(beats.size()), 32'(nexp));
        for (int i = 0; i < nexp && i < beats.size(); i++) begin
            idx = (dirty && i >= LW) ? i - LW : i;
            if (dirty && i < LW) begin
                ewe = 1'b1;
                ea  = vbase + 32'(idx * 4);
                ed  = snap[idx];
            end else begin
                ewe = 1'b0;
                ea  = mbase + 32'(idx * 4);
                ed  = mem_word(ea);
            end
            check("beat_we", 32'(beats[i].we), 32'(ewe));
            check("beat_addr", beats[i].addr, ea);
            check("beat_data", beats[i].data, ed);
        end
        for (int i = 0; i < LW; i++)
            check("cmem_line", cmem[sel][i], mem_word(mbase + 32'(i * 4)));
    endtask

    int          k0, wb0, rf0, nb;
    bit          seen0;
    logic [31:0] va0, va1, ea0;

    initial begin
        for (int e = 0; e < 2**SW; e++)
            for (int w = 0; w < LW; w++) cmem[e][w] = $urandom;
        rst               = 1'b1;
        line_miss         = 1'b0;
        replace_dirty     = 1'b0;
        force_sync        = 1'b0;
        entry_replace_sel = '0;
        miss_addr         = '0;
        victim_addr       = '0;
        bus_ack           = 1'b0;
        bus_rdata         = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_cm_we", 32'(cm_we), 32'd0);
        check("rst_line_refill", 32'(line_refill), 32'd0);
        check("rst_writeback_ok", 32'(writeback_ok), 32'd0);
        check("rst_refill_pa", refill_pa, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Clean miss, zero-wait, with completion latency
        run_txn(1'b0, 3'd2, 32'h0, 32'h0000_1234, 0, 1'b1);
        // Dirty miss: write-back then refill
        run_txn(1'b1, 3'd5, 32'h8000_0040, 32'h0000_2468, 0, 1'b0);
        // Ack every third cycle
        run_txn(1'b0, 3'd1, 32'h0, 32'h0000_ABC4, 1, 1'b0);
        run_txn(1'b1, 3'd6, 32'hFFFF_FFE8, 32'h1234_5670, 1, 1'b0);

        // force_sync across two dirty entries, no refill
        beats.delete();
        wb0 = n_wb;
        rf0 = n_rf;
        ack_mode = 2;
        va0 = $urandom;
        va1 = $urandom;
        for (int i = 0; i < LW; i++) begin
            snap[i]  = cmem[7][i];
            snap2[i] = cmem[3][i];
        end
        @(posedge clk);
        #1;
        force_sync        = 1'b1;
        replace_dirty     = 1'b1;
        entry_replace_sel = 3'd7;
        victim_addr       = va0;
        wait_pulse(1'b1, k0, seen0);
        check("fs_wb1", 32'(seen0), 32'd1);
        @(posedge clk);
        #1;
        entry_replace_sel = 3'd3;
        victim_addr       = va1;
        wait_pulse(1'b1, k0, seen0);
        check("fs_wb2", 32'(seen0), 32'd1);
        @(posedge clk);
        #1;
        replace_dirty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        force_sync = 1'b0;
        @(negedge clk);
        #3;
        check("fs_busy", 32'(busy), 32'd0);
        check("fs_wb_count", 32'(n_wb - wb0), 32'd2);
        check("fs_rf_count", 32'(n_rf - rf0), 32'd0);
        check("fs_beats", 32'(beats.size()), 32'(2 * LW));
        for (int i = 0; i < 2 * LW && i < beats.size(); i++) begin
            if (i < LW) ea0 = (va0 & MASK) + 32'(i * 4);
            else        ea0 = (va1 & MASK) + 32'((i - LW) * 4);
            check("fs_we", 32'(beats[i].we), 32'd1);
            check("fs_addr", beats[i].addr, ea0);
            check("fs_data", beats[i].data, (i < LW) ? snap[i] : snap2[i - LW]);
        end

        // Reset in the middle of a refill
        beats.delete();
        ack_mode = 0;
        @(posedge clk);
        #1;
        line_miss         = 1'b1;
        entry_replace_sel = 3'd4;
        miss_addr         = 32'h0000_7700;
        nb = 0;
        while (beats.size() < 4 && nb < 50) begin
            @(negedge clk);
            #3;
            nb++;
        end
        check("rst_mid_reached", 32'(beats.size() >= 4), 32'd1);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        line_miss = 1'b0;
        rf0       = n_rf;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #3;
        check("rst_mid_bus_req", 32'(bus_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #3;
        check("rst_mid_no_refill", 32'(n_rf - rf0), 32'd0);
        run_txn(1'b0, 3'd4, 32'h0, 32'h0000_7710, 0, 1'b1);

        // Spurious ack in IDLE with force_sync but nothing dirty
        wb0 = n_wb;
        rf0 = n_rf;
        ack_mode = 3;
        @(posedge clk);
        #1;
        force_sync    = 1'b1;
        replace_dirty = 1'b0;
        line_miss     = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #3;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_bus_req", 32'(bus_req), 32'd0);
        end
        force_sync = 1'b0;
        check("idle_no_pulse", 32'((n_wb - wb0) + (n_rf - rf0)), 32'd0);

        // Randomized requests against the line-level model
        for (int t = 0; t < 16; t++)
            run_txn(1'($urandom_range(0, 1)), SW'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 2)), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
